// File: rtl/dense_pkg.sv
// Shared types and helpers for the sequential dense layer.
package dense_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, EMIT} state_t;

  // Arithmetic (floor) right shift followed by saturation to a dw-bit signed range.
  // Works on a 64-bit sign-extended accumulator so one function serves any ACC_W.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int shift, input int dw);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/dense_mac.sv
// Multiply-accumulate datapath: one signed DW x DW product per cycle into an
// ACC_W register. 'load' seeds the register with bias + product, 'en' adds.
module dense_mac import dense_pkg::*; #(
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic [DW-1:0]           x,
  input  logic [DW-1:0]           w,
  input  logic [ACC_W-1:0]        b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x;

  // Full-precision product, then sign-extend into the accumulator width.
  assign prod   = signed'(x) * signed'(w);
  assign prod_x = ACC_W'(prod);

  // Accumulator register; sums wrap modulo 2^ACC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc <= '0;
    else if (load) acc <= signed'(b) + prod_x;
    else if (en)   acc <= acc + prod_x;
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: collects an N_IN vector, then for each of
// N_OUT neurons streams weights from a synchronous ROM, accumulates, requantises
// and emits one result. Define DENSE_RELU_EN to clamp negative results to 0.
module dense_layer_seq import dense_pkg::*; #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  localparam int AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [AW-1:0]    w_addr,
  input  logic [DW-1:0]    w_data,
  output logic [BW-1:0]    b_addr,
  input  logic [ACC_W-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] I_LAST = CW'(N_IN - 1);
  localparam logic [BW-1:0] O_LAST = BW'(N_OUT - 1);

  if (ACC_W < 2 * DW + $clog2(N_IN)) begin : g_acc_chk
    $error("dense_layer_seq: ACC_W too narrow for N_IN products of DW bits");
  end

  state_t                   state, state_nx;
  logic [N_IN-1:0][DW-1:0]  x;
  logic [CW-1:0]            in_cnt, cnt, rcnt;
  logic [BW-1:0]            o, o_nx;
  // [0] address on w_addr, [1] w_data returning, [2] accumulator final
  logic [2:0]               vld_pipe;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DW-1:0]     res;

  // Neuron index for the COMPUTE pass about to start.
  assign o_nx = (state == EMIT) ? o + 1'b1 : '0;

  // Requantise the finished accumulator, optionally applying ReLU.
  always_comb begin
    res = DW'(requant(64'(acc), SHIFT, DW));
`ifdef DENSE_RELU_EN
    if (res[DW-1]) res = '0;
`else
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_cnt == I_LAST) ? COMPUTE : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_cnt == I_LAST) state_nx = COMPUTE;
      end
      COMPUTE: if (vld_pipe[2]) state_nx = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (o == O_LAST);
        if (out_ready) state_nx = (o == O_LAST) ? IDLE : COMPUTE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input capture, ROM address sequencing, valid pipeline and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      in_cnt   <= '0;
      cnt      <= '0;
      rcnt     <= '0;
      o        <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      vld_pipe <= '0;
      out_data <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      vld_pipe[2] <= vld_pipe[1] && (rcnt == I_LAST);
      if (in_valid && in_ready) begin
        x[in_cnt] <= in_data;
        in_cnt    <= (in_cnt == I_LAST) ? '0 : in_cnt + 1'b1;
      end
      if (vld_pipe[0]) begin
        rcnt <= cnt;
        if (cnt == I_LAST) vld_pipe[0] <= 1'b0;
        else begin
          cnt    <= cnt + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
      end
      // Entering COMPUTE: point both ROMs at the new neuron's first entries.
      if (state != COMPUTE && state_nx == COMPUTE) begin
        o           <= o_nx;
        b_addr      <= o_nx;
        w_addr      <= AW'(o_nx * N_IN);
        cnt         <= '0;
        vld_pipe[0] <= 1'b1;
      end
      if (vld_pipe[2]) out_data <= res;
    end
  end

  dense_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .load (vld_pipe[1] && rcnt == '0),
    .en   (vld_pipe[1]),
    .x    (x[rcnt]),
    .w    (w_data),
    .b    (b_data),
    .acc  (acc)
  );

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: two instances (SHIFT=0 and SHIFT=2) run in
// lockstep on the same vectors, each with its own ROM model, checked against
// a dot-product/floor/clamp reference.
module tb_dense_layer_seq;
  localparam int NI = 4;
  localparam int NO = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1, busy0, busy1;
  logic [2:0] w_addr0, w_addr1;
  logic [0:0] b_addr0, b_addr1;
  logic [7:0] w_data0, w_data1;
  logic [23:0] b_data0, b_data1;
  logic signed [7:0] out_data0, out_data1;

  int wv[NI*NO];
  int bv[NO];
  int xv[NI];
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int t_hs = 0, t_emit = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROMs, one cycle latency.
  always @(posedge clk) begin
    w_data0 <= 8'(wv[w_addr0]);
    b_data0 <= 24'(bv[b_addr0]);
    w_data1 <= 8'(wv[w_addr1]);
    b_data1 <= 24'(bv[b_addr1]);
  end

  dense_layer_seq #(.N_IN(NI), .N_OUT(NO), .DW(8), .ACC_W(24), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0));

  dense_layer_seq #(.N_IN(NI), .N_OUT(NO), .DW(8), .ACC_W(24), .SHIFT(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: bias + dot product, floor-divide by 2^sh, clamp to int8.
  function automatic longint model(input int o, input int sh);
    longint a, d, q;
    a = bv[o];
    for (int i = 0; i < NI; i++) a += longint'(xv[i]) * longint'(wv[o*NI+i]);
    d = longint'(1) << sh;
    q = a / d;
    if (a < 0 && (a % d) != 0) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
`ifdef DENSE_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic send();
    for (int k = 0; k < NI; k++) begin
      repeat ($urandom_range(0, 1)) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data  = 8'(xv[k]);
      for (int n = 0; n < 100 && !in_ready0; n++) @(negedge clk);
      @(posedge clk);
      #1 t_hs = cyc;
      @(negedge clk);
    end
    // Junk beat held during COMPUTE; must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h5a;
  endtask

  task automatic collect(input int stall);
    logic signed [7:0] held;
    for (int o = 0; o < NO; o++) begin
      for (int n = 0; n < 100 && !out_valid0; n++) @(negedge clk);
      in_valid = 1'b0;
      if (!out_valid0) begin chk("out_valid_timeout", 0, 1); return; end
      chk(o == 0 ? "latency_first" : "latency_next", cyc - (o == 0 ? t_hs : t_emit), NI + 2);
      chk("data_shift0", out_data0, model(o, 0));
      chk("data_shift2", out_data1, model(o, 2));
      chk("last_shift0", out_last0, o == NO - 1);
      chk("last_shift2", out_last1, o == NO - 1);
      chk("in_ready_emit", in_ready0, 0);
      if (stall > 0 && o == 0) begin
        out_ready = 1'b0;
        held = out_data0;
        repeat (stall) begin
          @(negedge clk);
          chk("stall_valid", out_valid0, 1);
          chk("stall_data", out_data0, held);
          chk("stall_in_ready", in_ready0, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1 t_emit = cyc;
      @(negedge clk);
    end
    chk("idle_busy", busy0, 0);
    chk("idle_in_ready", in_ready0, 1);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < NI*NO; j++) wv[j] = int'($urandom_range(0, 255)) - 128;
    for (int o = 0; o < NO; o++) bv[o] = int'($urandom_range(0, 2**21)) - 2**20;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int j = 0; j < NI*NO; j++) wv[j] = 0;
    for (int o = 0; o < NO; o++) bv[o] = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_w_addr", w_addr0, 0);
    chk("rst_b_addr", b_addr0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);

    // Basic sums: 1+2+3+4 with bias 10, and the negated sum.
    xv = '{1, 2, 3, 4};
    for (int i = 0; i < NI; i++) begin wv[i] = 1; wv[NI+i] = -1; end
    bv = '{10, 0};
    send(); collect(0);

    // Saturation at both rails.
    xv = '{127, 127, 127, 127};
    for (int i = 0; i < NI; i++) begin wv[i] = 127; wv[NI+i] = -128; end
    bv = '{0, 0};
    send(); collect(0);

    // acc = -5: floor shift gives -2 at SHIFT=2.
    xv = '{1, 0, 0, 0};
    wv = '{-5, 0, 0, 0, 1, 0, 0, 0};
    bv = '{0, 2};
    send(); collect(0);

    // Backpressure for 5 cycles in EMIT.
    rand_vec(); send(); collect(5);

    // Reset in the middle of COMPUTE, then a fresh vector.
    rand_vec(); send();
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_busy", busy0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready0, 1);
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid0 || out_valid1) seen = 1; end
    chk("midrst_no_output", seen, 0);
    rand_vec(); send(); collect(0);

    // Random traffic with random backpressure.
    for (int t = 0; t < 8; t++) begin
      rand_vec(); send(); collect(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
